// File: rtl/sorted_list_streamer_pkg.sv
// Shared constants, FSM encoding and rank helper for the sorted-list streamer.
// Rank 0 (the smallest distance) sits in the least significant WIDTH bits of the packed list.
package sorted_list_streamer_pkg;

  localparam int WIDTH = 16;
  localparam int N     = 16;
  localparam int IDXW  = $clog2(N);
  localparam int CNTW  = IDXW + 1;

  typedef logic [WIDTH-1:0]   entry_t;
  typedef logic [N*WIDTH-1:0] list_t;
  typedef logic [IDXW-1:0]    idx_t;
  typedef logic [CNTW-1:0]    cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Extracts one rank from a packed list, using the same ordering as the sorter.
  function automatic entry_t rank_slice(input list_t list, input int unsigned rank);
    return list[rank*WIDTH +: WIDTH];
  endfunction

endpackage

// File: rtl/sorted_list_streamer_if.sv
// Control and output stream bundle of the sorted-list streamer.
// The master side is the streamer; the slave side is the sorter/consumer environment.
interface sorted_list_streamer_if;
  import sorted_list_streamer_pkg::*;

  logic   start;
  cnt_t   count;
  list_t  in_list;
  logic   busy;
  logic   out_valid;
  logic   out_ready;
  entry_t out_data;
  idx_t   out_idx;
  logic   out_last;
  logic   done;

  modport master (
    input  start, count, in_list, out_ready,
    output busy, out_valid, out_data, out_idx, out_last, done
  );

  modport slave (
    output start, count, in_list, out_ready,
    input  busy, out_valid, out_data, out_idx, out_last, done
  );

endinterface

// File: rtl/sorted_list_shreg.sv
// Loadable shadow register for the sorted list; each shift drops the current rank
// and moves the next one down into the low slice.
module sorted_list_shreg
  import sorted_list_streamer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   shift,
  input  list_t  d,
  output entry_t q_low
);

  list_t q;

  // Capture on load, otherwise shift right by one entry; load wins if both are asserted.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      // NOTE: this is a wide register, not a RAM, so it takes the reset; out_data then reads 0.
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> WIDTH;
    end
  end

  assign q_low = rank_slice(q, 0);

endmodule

// File: rtl/sorted_list_streamer.sv
// Captures a sorted distance list on start and streams the first count ranks
// over a valid/ready handshake, tagging each with its rank and a last flag.
module sorted_list_streamer
  import sorted_list_streamer_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  sorted_list_streamer_if.master bus
);

  state_t state_q, state_d;
  cnt_t   remaining_q;
  idx_t   idx_q;
  entry_t shadow_low;
  cnt_t   load_count;
  logic   accept_run;
  logic   xfer;
  logic   last_xfer;

  // A run with at least one entry loads the shadow; count=0 skips straight to FINISH.
  assign accept_run = (state_q == IDLE) && bus.start && (bus.count != '0);
  assign xfer       = (state_q == STREAM) && bus.out_ready;
  assign last_xfer  = xfer && (remaining_q == cnt_t'(1));
  assign load_count = (bus.count > cnt_t'(N)) ? cnt_t'(N) : bus.count;

  sorted_list_shreg u_shreg (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_run),
    .shift (xfer),
    .d     (bus.in_list),
    .q_low (shadow_low)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.count == '0) ? FINISH : STREAM;
      STREAM:  if (last_xfer) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rank index and remaining-entry counter; remaining is clamped on load and never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_q <= '0;
      idx_q       <= '0;
    end else if (accept_run) begin
      remaining_q <= load_count;
      idx_q       <= '0;
    end else if (xfer) begin
      idx_q <= idx_q + idx_t'(1);
      if (remaining_q != '0) remaining_q <= remaining_q - cnt_t'(1);
    end
  end

  // Output decode from the current state.
  always_comb begin
    bus.busy      = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.done      = 1'b0;
    bus.out_data  = shadow_low;
    bus.out_idx   = idx_q;
    case (state_q)
      STREAM: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_last  = (remaining_q == cnt_t'(1));
      end
      FINISH:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sorted_list_streamer.sv
// Self-checking bench for sorted_list_streamer: a cycle table for the backpressured
// partial run plus directed sequences for full, zero, clamp, isolation, reset and back-to-back runs.
module tb_sorted_list_streamer;
  import sorted_list_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sorted_list_streamer_if bus ();

  sorted_list_streamer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic   start;
    cnt_t   count;
    logic   ready;
    logic   exp_valid;
    entry_t exp_data;
    idx_t   exp_idx;
    logic   exp_last;
    logic   exp_busy;
    logic   exp_done;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic list_t make_list(input entry_t base);
    list_t l;
    for (int i = 0; i < N; i++) l[i*WIDTH +: WIDTH] = base + entry_t'(i);
    return l;
  endfunction

  task automatic check_beat(input string tag, input entry_t data, input int idx, input logic last);
    check({tag, " valid"}, bus.out_valid, 1);
    check({tag, " data"},  bus.out_data,  data);
    check({tag, " idx"},   bus.out_idx,   idx);
    check({tag, " last"},  bus.out_last,  last);
    check({tag, " busy"},  bus.busy,      1);
  endtask

  initial begin
    int  beats;
    logic seen_done;

    // Backpressured partial run: count=3, ready low for 4 cycles after first valid.
    tbl[0] = '{1'b1, 5'd3, 1'b0, 1'b1, 16'h0100, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 5'd3, 1'b0, 1'b1, 16'h0100, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 5'd3, 1'b0, 1'b1, 16'h0100, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 5'd3, 1'b0, 1'b1, 16'h0100, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 5'd3, 1'b0, 1'b1, 16'h0100, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 5'd3, 1'b1, 1'b1, 16'h0101, 4'd1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 5'd3, 1'b1, 1'b1, 16'h0102, 4'd2, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 5'd3, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 5'd3, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 5'd3, 1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.count     = '0;
    bus.in_list   = '0;
    bus.out_ready = 1'b0;
    step();
    step();

    // Reset state.
    check("rst busy",  bus.busy,      0);
    check("rst valid", bus.out_valid, 0);
    check("rst last",  bus.out_last,  0);
    check("rst done",  bus.done,      0);
    check("rst data",  bus.out_data,  0);
    check("rst idx",   bus.out_idx,   0);
    rst = 1'b0;
    step();

    // Full run at full throughput.
    bus.in_list   = make_list(16'h0001);
    bus.count     = 5'd16;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_beat($sformatf("full[%0d]", k), 16'h0001 + entry_t'(k), k, k == 15);
      step();
    end
    check("full done",       bus.done,      1);
    check("full valid off",  bus.out_valid, 0);
    check("full busy off",   bus.busy,      0);
    step();
    check("full done pulse", bus.done,      0);
    check("full busy after", bus.busy,      0);

    // Partial run with backpressure, table-driven.
    bus.in_list = make_list(16'h0100);
    for (int r = 0; r < 10; r++) begin
      bus.start     = tbl[r].start;
      bus.count     = tbl[r].count;
      bus.out_ready = tbl[r].ready;
      step();
      check($sformatf("bp[%0d] valid", r), bus.out_valid, tbl[r].exp_valid);
      check($sformatf("bp[%0d] last", r),  bus.out_last,  tbl[r].exp_last);
      check($sformatf("bp[%0d] busy", r),  bus.busy,      tbl[r].exp_busy);
      check($sformatf("bp[%0d] done", r),  bus.done,      tbl[r].exp_done);
      if (tbl[r].exp_valid) begin
        check($sformatf("bp[%0d] data", r), bus.out_data, tbl[r].exp_data);
        check($sformatf("bp[%0d] idx", r),  bus.out_idx,  tbl[r].exp_idx);
      end
    end
    bus.start = 1'b0;

    // Zero count: no beat, done one cycle after start.
    bus.count = 5'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("zero valid", bus.out_valid, 0);
    check("zero busy",  bus.busy,      0);
    check("zero done",  bus.done,      1);
    step();
    check("zero done pulse", bus.done,      0);
    check("zero valid2",     bus.out_valid, 0);

    // Clamp: count=31 yields exactly N beats.
    bus.in_list   = make_list(16'h0001);
    bus.count     = 5'd31;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    beats     = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (bus.out_valid && bus.out_ready) beats++;
      if (bus.done) seen_done = 1'b1;
      else step();
    end
    check("clamp done seen", seen_done, 1);
    check("clamp beats",     beats,     16);
    step();

    // Ignored start and input isolation.
    bus.in_list = make_list(16'hA000);
    bus.count   = 5'd4;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b1;
    bus.count   = 5'd16;
    bus.in_list = make_list(16'hF000);
    check_beat("iso[0]", 16'hA000, 0, 1'b0);
    step();
    bus.start = 1'b0;
    for (int k = 1; k < 4; k++) begin
      check_beat($sformatf("iso[%0d]", k), 16'hA000 + entry_t'(k), k, k == 3);
      step();
    end
    check("iso done", bus.done, 1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("iso finish start valid", bus.out_valid, 0);
    check("iso finish start busy",  bus.busy,      0);
    step();
    check("iso no rerun valid", bus.out_valid, 0);
    check("iso no rerun done",  bus.done,      0);

    // Reset mid-run at idx 5.
    bus.in_list = make_list(16'h0200);
    bus.count   = 5'd16;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check_beat("mid pre", 16'h0205, 5, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid valid", bus.out_valid, 0);
    check("mid busy",  bus.busy,      0);
    check("mid idx",   bus.out_idx,   0);
    check("mid data",  bus.out_data,  0);
    check("mid done",  bus.done,      0);
    step();
    check("mid no done", bus.done,      0);
    check("mid idle",    bus.out_valid, 0);
    bus.in_list = make_list(16'h0300);
    bus.count   = 5'd2;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    check_beat("post[0]", 16'h0300, 0, 1'b0);
    step();
    check_beat("post[1]", 16'h0301, 1, 1'b1);
    step();
    check("post done", bus.done, 1);

    // Back-to-back: start in the cycle after done.
    bus.in_list = make_list(16'h0400);
    bus.count   = 5'd1;
    step();
    check("b2b idle done",  bus.done,      0);
    check("b2b idle valid", bus.out_valid, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_beat("b2b[0]", 16'h0400, 0, 1'b1);
    step();
    check("b2b done", bus.done, 1);
    step();
    check("b2b done pulse", bus.done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sorted_list_streamer.md
Name: sorted_list_streamer

Overview:
- Consumer end of the distance sorter. Captures the packed, ascending-sorted squared-distance list on a start pulse.
- Streams the first COUNT entries out one per transfer over a valid/ready handshake, each tagged with its rank index and a last flag.
- Sits between the sorter's packed output bus and downstream candidate-selection / detection logic.

Parameters:
- WIDTH, 16, bit width of one squared-distance entry.
- N, 16, number of entries in the packed list (2*n of the sorter, n=8).
- IDXW, 4, rank index width; must equal clog2(N).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to capture in_list and begin streaming
- count  in  IDXW+1  number of entries to emit, sampled with start
- in_list  in  N*WIDTH  packed sorted list; slice [WIDTH*(i+1)-1:WIDTH*i] is rank i, rank 0 is the smallest
- busy  out  1  high from the cycle after an accepted start until done
- out_valid  out  1  out_data/out_idx/out_last are valid
- out_ready  in  1  downstream accepts the current entry
- out_data  out  WIDTH  current entry
- out_idx  out  IDXW  rank of the current entry
- out_last  out  1  current entry is the final one of this run
- done  out  1  one-cycle pulse when a run completes

Behaviour:
- Reset: rst=1 at a clock edge forces IDLE. busy, out_valid, out_last and done go to 0; out_data, out_idx, the shadow register and the counter go to 0.
- Reset mid-run aborts immediately. Any pending entry is dropped and no done pulse is generated.
- FSM states: IDLE, STREAM, FINISH.
- IDLE, start=1 and count>=1:
  - Capture in_list into the shadow register.
  - Set remaining = min(count, N) and idx=0.
  - Go to STREAM. Next cycle: out_valid=1, busy=1, out_data = rank 0.
- IDLE, start=1 and count=0: go to FINISH. No valid beat is produced.
- count>N is clamped to N.
- STREAM:
  - Transfer occurs on a cycle where out_valid and out_ready are both 1.
  - On transfer: shadow shifts right by WIDTH, idx increments, remaining decrements.
  - out_data always equals shadow[WIDTH-1:0]; out_idx equals idx.
  - out_last = (remaining==1) while out_valid.
  - A transfer with out_last=1 goes to FINISH and deasserts out_valid on the next cycle.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE.
- start is ignored outside IDLE, including in FINISH. in_list changes after capture have no effect on the run.
- Outputs are stable while out_valid=1 and out_ready=0. Backpressure may last any number of cycles.
- Latency:
  - start to first out_valid: 1 cycle.
  - Full-throughput run of K entries: K cycles of valid.
  - done arrives 1 cycle after the last transfer.
  - A new start is accepted the cycle after done.
- Arithmetic: no arithmetic on the data path. The remaining counter is IDXW+1 bits and never wraps: clamp on load, stop at 0.

Decomposition:
- Shared package holds:
  - Constants WIDTH and N, plus IDXW derived via clog2.
  - FSM state encoding (IDLE=2'd0, STREAM=2'd1, FINISH=2'd2).
  - The rank-slice helper, so the sorter and this block agree on rank-0-at-LSB ordering.
- One natural sub-module: sorted_list_shreg. It is the N*WIDTH loadable shift-by-WIDTH register, with ports load, shift, d, q_low.
- FSM, counters and handshake stay in the top.

Test Plan:
- Full run at full throughput. Stimulus: in_list ranks 0..15 = 0x0001..0x0010, count=16, out_ready held 1. Response: 16 beats with out_data 0x0001..0x0010 and out_idx 0..15; out_last only on idx 15; done pulses the cycle after; busy is 0 after done.
- Partial run with backpressure. Stimulus: count=3, out_ready low for 4 cycles after the first valid. Response: rank 0 is held stable during the stall; beats are rank 0, 1, 2; out_last on idx 2; ranks 3..15 are never emitted.
- Zero and clamp. Stimulus: count=0. Response: no out_valid and done 1 cycle after start. Stimulus: count=31 (5'd31). Response: exactly 16 beats.
- Ignored start and input isolation. Stimulus: start pulse with different in_list while busy, and in_list changes mid-run. Response: the original captured values stream unchanged; no second run begins.
- Reset mid-run. Stimulus: rst=1 during STREAM at idx 5. Response: next cycle out_valid=0, busy=0, out_idx=0 and no done pulse. A subsequent start with count=2 streams ranks 0 and 1 of the new list.
- Back-to-back runs. Stimulus: start on the cycle after done. Response: accepted; first beat appears 1 cycle later.
